// File: rtl/adc_ctrl_pkg.sv
// Shared encodings for the ADC command sequencer: ADC_FSM state codes, host
// command codes, error codes, sequencer states and command legality helpers.
package adc_ctrl_pkg;

  // Only the ADC_FSM states the sequencer reasons about are named here.
  typedef enum logic [3:0] {
    ALL_PWR_OFF         = 4'd0,
    DES_SAMPLING        = 4'd8,
    LOW_PWR_IDLE        = 4'd10,
    PERIPH_PWR_SHUTDOWN = 4'd13,
    CLOCK_LOCK          = 4'd14
  } adc_state_e;

  typedef enum logic [2:0] {
    CMD_NONE    = 3'd0,
    CMD_PWR_ON  = 3'd1,
    CMD_PWR_OFF = 3'd2,
    CMD_SLEEP   = 3'd3,
    CMD_WAKE    = 3'd4,
    CMD_RUN_CAL = 3'd5
  } cmd_code_e;

  typedef enum logic [2:0] {
    ERR_NONE          = 3'd0,
    ERR_BAD_CODE      = 3'd1,
    ERR_ILLEGAL_STATE = 3'd2,
    ERR_TIMEOUT       = 3'd3,
    ERR_ABORTED       = 3'd4
  } err_code_e;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_WAIT,
    SEQ_DONE,
    SEQ_ERROR
  } seq_state_e;

  function automatic logic cmdIsValid(input logic [2:0] code);
    return (code >= CMD_PWR_ON) && (code <= CMD_RUN_CAL);
  endfunction

  function automatic logic cmdIsLegal(input logic [2:0] code, input logic [3:0] st);
    case (code)
      CMD_PWR_ON:  return st == ALL_PWR_OFF;
      CMD_PWR_OFF: return (st == DES_SAMPLING) || (st == LOW_PWR_IDLE);
      CMD_SLEEP:   return st == DES_SAMPLING;
      CMD_WAKE:    return st == LOW_PWR_IDLE;
      CMD_RUN_CAL: return st == DES_SAMPLING;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] cmdTarget(input logic [2:0] code);
    case (code)
      CMD_PWR_ON:  return DES_SAMPLING;
      CMD_PWR_OFF: return ALL_PWR_OFF;
      CMD_SLEEP:   return LOW_PWR_IDLE;
      CMD_WAKE:    return DES_SAMPLING;
      CMD_RUN_CAL: return DES_SAMPLING;
      default:     return ALL_PWR_OFF;
    endcase
  endfunction

endpackage

// File: rtl/adc_cmd_sequencer_if.sv
// Host command channel of the ADC command sequencer: request handshake plus
// completion/error reporting back to the command decoder.
interface adc_cmd_sequencer_if;
  logic       CmdValid;
  logic [2:0] CmdCode;
  logic       CmdReady;
  logic       CmdDone;
  logic       CmdError;
  logic [2:0] ErrCode;
  logic       DoneSrc;

  modport master (
    output CmdValid, CmdCode,
    input  CmdReady, CmdDone, CmdError, ErrCode, DoneSrc
  );

  modport slave (
    input  CmdValid, CmdCode,
    output CmdReady, CmdDone, CmdError, ErrCode, DoneSrc
  );
endinterface

// File: rtl/adc_autocal_timer.sv
// Idle-time counter for periodic recalibration; saturates at CAL_PERIOD-1 and
// raises Pending there until cleared.
module adc_autocal_timer #(
  parameter int unsigned CAL_PERIOD = 100000000,
  parameter int unsigned CAL_CNT_W  = 27
) (
  input  logic Clock,
  input  logic Reset,
  input  logic CountEn,
  input  logic Clear,
  input  logic ClearPending,
  output logic Pending
);

  localparam logic [CAL_CNT_W-1:0] LAST = CAL_CNT_W'(CAL_PERIOD - 1);

  logic [CAL_CNT_W-1:0] count;

  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      count   <= '0;
      Pending <= 1'b0;
    end else begin
      if (ClearPending) begin
        Pending <= 1'b0;
      end
      if (CountEn) begin
        if (count == LAST) begin
          Pending <= 1'b1;
        end else begin
          count <= count + CAL_CNT_W'(1);
          // Flag on the same edge the count reaches its final value.
          if (count == LAST - CAL_CNT_W'(1)) begin
            Pending <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/adc_cmd_sequencer.sv
// Single-command-in-flight scheduler in front of ADC_FSM: validates host and
// auto-calibration requests, issues one control pulse, and tracks completion.
module adc_cmd_sequencer
  import adc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_W  = 28,
  parameter int unsigned CAL_PERIOD = 100000000,
  parameter int unsigned CAL_CNT_W  = 27
) (
  input  logic                      Clock,
  input  logic                      Reset,
  adc_cmd_sequencer_if.slave        cmdBus,
  input  logic                      AutoCalEnable,
  input  logic [3:0]                AdcState,
  output logic                      adcPwrOn,
  output logic                      adcPwrOff,
  output logic                      adcSleep,
  output logic                      adcWake,
  output logic                      adcRunCal,
  output logic                      Busy
);

  seq_state_e           state;
  seq_state_e           stateNext;
  logic [2:0]           code;
  logic                 source;
  logic [3:0]           origin;
  logic [3:0]           target;
  logic [TIMEOUT_W-1:0] timer;
  logic [TIMEOUT_W-1:0] timerNext;
  logic                 left;
  logic                 leftNow;
  err_code_e            errCode;
  err_code_e            errNext;
  logic                 startHost;
  logic                 startAuto;
  logic [2:0]           issueCode;
  logic                 goIssue;
  logic                 autoPending;
  logic                 isIdle;
  logic                 atSampling;
  logic                 calCountEn;
  logic                 calClear;
  logic                 calClearPending;

  assign isIdle     = (state == SEQ_IDLE);
  assign atSampling = (AdcState == DES_SAMPLING);
  assign target     = cmdTarget(code);
  assign timerNext  = timer + TIMEOUT_W'(1);
  // Include the current cycle so a departure is seen without an extra cycle.
  assign leftNow    = left || (AdcState != origin);

  always_comb begin
    stateNext = state;
    errNext   = ERR_NONE;
    startHost = 1'b0;
    startAuto = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (cmdBus.CmdValid) begin
          startHost = 1'b1;
          if (!cmdIsValid(cmdBus.CmdCode)) begin
            stateNext = SEQ_ERROR;
            errNext   = ERR_BAD_CODE;
          end else if (!cmdIsLegal(cmdBus.CmdCode, AdcState)) begin
            stateNext = SEQ_ERROR;
            errNext   = ERR_ILLEGAL_STATE;
          end else begin
            stateNext = SEQ_ISSUE;
          end
        end else if (autoPending && atSampling) begin
          startAuto = 1'b1;
          stateNext = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: stateNext = SEQ_WAIT;
      SEQ_WAIT: begin
        if (leftNow && (AdcState == target)) begin
          stateNext = SEQ_DONE;
        end else if (leftNow && (AdcState == ALL_PWR_OFF) && (target != ALL_PWR_OFF)) begin
          stateNext = SEQ_ERROR;
          errNext   = ERR_ABORTED;
        end else if (&timerNext) begin
          stateNext = SEQ_ERROR;
          errNext   = ERR_TIMEOUT;
        end
      end
      SEQ_DONE:  stateNext = SEQ_IDLE;
      SEQ_ERROR: stateNext = SEQ_IDLE;
      default:   stateNext = SEQ_IDLE;
    endcase
  end

  assign issueCode = startAuto ? CMD_RUN_CAL : cmdBus.CmdCode;
  assign goIssue   = isIdle && (stateNext == SEQ_ISSUE);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= SEQ_IDLE;
      code      <= CMD_NONE;
      source    <= 1'b0;
      origin    <= '0;
      timer     <= '0;
      left      <= 1'b0;
      errCode   <= ERR_NONE;
      adcPwrOn  <= 1'b0;
      adcPwrOff <= 1'b0;
      adcSleep  <= 1'b0;
      adcWake   <= 1'b0;
      adcRunCal <= 1'b0;
    end else begin
      state <= stateNext;
      if (startHost || startAuto) begin
        code    <= issueCode;
        source  <= startAuto;
        origin  <= AdcState;
        errCode <= ERR_NONE;
      end
      if (stateNext == SEQ_ERROR) begin
        errCode <= errNext;
      end
      if (state == SEQ_ISSUE) begin
        timer <= '0;
        left  <= 1'b0;
      end else if (state == SEQ_WAIT) begin
        timer <= timerNext;
        left  <= leftNow;
      end
      adcPwrOn  <= goIssue && (issueCode == CMD_PWR_ON);
      adcPwrOff <= goIssue && (issueCode == CMD_PWR_OFF);
      adcSleep  <= goIssue && (issueCode == CMD_SLEEP);
      adcWake   <= goIssue && (issueCode == CMD_WAKE);
      adcRunCal <= goIssue && (issueCode == CMD_RUN_CAL);
    end
  end

  // Counter runs only while idle at DES_SAMPLING; any completed RUN_CAL restarts it.
  assign calCountEn      = AutoCalEnable && isIdle && atSampling;
  assign calClear        = (isIdle && !(AutoCalEnable && atSampling)) ||
                           ((state == SEQ_DONE) && (source || (code == CMD_RUN_CAL)));
  assign calClearPending = (state == SEQ_ERROR) && source;

  adc_autocal_timer #(
    .CAL_PERIOD (CAL_PERIOD),
    .CAL_CNT_W  (CAL_CNT_W)
  ) u_autocal (
    .Clock        (Clock),
    .Reset        (Reset),
    .CountEn      (calCountEn),
    .Clear        (calClear),
    .ClearPending (calClearPending),
    .Pending      (autoPending)
  );

  assign Busy            = !isIdle;
  assign cmdBus.CmdReady = isIdle;
  assign cmdBus.CmdDone  = (state == SEQ_DONE);
  assign cmdBus.CmdError = (state == SEQ_ERROR);
  assign cmdBus.ErrCode  = errCode;
  assign cmdBus.DoneSrc  = source;

endmodule

// File: tb/tb_adc_cmd_sequencer.sv
// Scoreboard bench for adc_cmd_sequencer: directed ADC state sequences, with
// completions checked against expectations queued when each command is driven.
module tb_adc_cmd_sequencer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       AutoCalEnable;
  logic [3:0] AdcState;
  logic       adcPwrOn, adcPwrOff, adcSleep, adcWake, adcRunCal;
  logic       Busy;
  logic [4:0] pv;
  logic [4:0] prevPv;
  logic [4:0] pulseSeen;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic       isErr;
    logic [2:0] err;
    logic       src;
    logic [4:0] pulse;
  } exp_t;

  exp_t expQ[$];

  adc_cmd_sequencer_if cmdBus();

  adc_cmd_sequencer #(
    .TIMEOUT_W  (6),
    .CAL_PERIOD (20),
    .CAL_CNT_W  (5)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .cmdBus        (cmdBus),
    .AutoCalEnable (AutoCalEnable),
    .AdcState      (AdcState),
    .adcPwrOn      (adcPwrOn),
    .adcPwrOff     (adcPwrOff),
    .adcSleep      (adcSleep),
    .adcWake       (adcWake),
    .adcRunCal     (adcRunCal),
    .Busy          (Busy)
  );

  always #5 Clock = ~Clock;

  // Bit (code-1) set for each command pulse.
  assign pv = {adcRunCal, adcWake, adcSleep, adcPwrOff, adcPwrOn};

  task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic pushExp(input logic isErr, input logic [2:0] err, input logic src,
                         input logic [4:0] pulse);
    exp_t e;
    e.isErr = isErr;
    e.err   = err;
    e.src   = src;
    e.pulse = pulse;
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Returns #1 after the handshake edge.
  task automatic hostCmd(input logic [2:0] code);
    int n = 0;
    while (!cmdBus.CmdReady && n < 100) begin
      tick();
      n++;
    end
    if (!cmdBus.CmdReady) checkEq("ready_wait", cmdBus.CmdReady, 1);
    cmdBus.CmdValid = 1'b1;
    cmdBus.CmdCode  = code;
    tick();
    cmdBus.CmdValid = 1'b0;
    cmdBus.CmdCode  = 3'd0;
  endtask

  always @(negedge Clock) begin
    if (Reset) begin
      pulseSeen = '0;
      prevPv    = '0;
    end else begin
      if (pv != 5'd0) begin
        checkEq("pulse_onehot", $onehot(pv), 1);
        checkEq("pulse_width", pv & prevPv, 0);
      end
      pulseSeen = pulseSeen | pv;
      prevPv    = pv;
      if (cmdBus.CmdDone || cmdBus.CmdError) begin
        checkEq("sb_nonempty", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          exp_t e;
          e = expQ.pop_front();
          checkEq("sb_kind_err", cmdBus.CmdError, e.isErr);
          checkEq("sb_kind_done", cmdBus.CmdDone, !e.isErr);
          checkEq("sb_errcode", cmdBus.ErrCode, e.err);
          checkEq("sb_donesrc", cmdBus.DoneSrc, e.src);
          checkEq("sb_pulse", pulseSeen, e.pulse);
        end
        pulseSeen = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, required finish before limit", $time);
    $fatal(1);
  end

  initial begin
    logic [3:0] pwrSeq[9] = '{4'd1, 4'd2, 4'd14, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    logic [3:0] calSeq[5] = '{4'd12, 4'd5, 4'd6, 4'd7, 4'd8};

    Reset           = 1'b1;
    AutoCalEnable   = 1'b0;
    AdcState        = 4'd0;
    cmdBus.CmdValid = 1'b0;
    cmdBus.CmdCode  = 3'd0;
    repeat (3) tick();
    Reset = 1'b0;
    checkEq("rst_busy", Busy, 0);
    checkEq("rst_ready", cmdBus.CmdReady, 1);
    checkEq("rst_pulses", pv, 0);
    checkEq("rst_done", cmdBus.CmdDone, 0);
    checkEq("rst_error", cmdBus.CmdError, 0);
    checkEq("rst_errcode", cmdBus.ErrCode, 0);
    checkEq("rst_donesrc", cmdBus.DoneSrc, 0);

    // PWR_ON walk through the power-up sequence
    pushExp(1'b0, 3'd0, 1'b0, 5'b00001);
    hostCmd(3'd1);
    checkEq("pwron_pulse", pv, 5'b00001);
    checkEq("pwron_busy", Busy, 1);
    tick();
    checkEq("pwron_pulse_end", pv, 0);
    foreach (pwrSeq[i]) begin
      AdcState = pwrSeq[i];
      tick();
      if (pwrSeq[i] != 4'd8) checkEq("pwron_no_early_done", cmdBus.CmdDone, 0);
    end
    checkEq("pwron_done", cmdBus.CmdDone, 1);
    checkEq("pwron_src", cmdBus.DoneSrc, 0);
    tick();
    checkEq("pwron_ready", cmdBus.CmdReady, 1);

    // WAKE from DES_SAMPLING is illegal
    pushExp(1'b1, 3'd2, 1'b0, 5'b00000);
    hostCmd(3'd4);
    checkEq("wake_err", cmdBus.CmdError, 1);
    checkEq("wake_errcode", cmdBus.ErrCode, 2);
    checkEq("wake_nopulse", pv, 0);
    tick();

    // Invalid code 7
    pushExp(1'b1, 3'd1, 1'b0, 5'b00000);
    hostCmd(3'd7);
    checkEq("bad_err", cmdBus.CmdError, 1);
    checkEq("bad_errcode", cmdBus.ErrCode, 1);
    tick();
    checkEq("errcode_hold", cmdBus.ErrCode, 1);
    checkEq("err_pulse_end", cmdBus.CmdError, 0);

    // RUN_CAL completes only after leaving and re-entering DES_SAMPLING
    pushExp(1'b0, 3'd0, 1'b0, 5'b10000);
    hostCmd(3'd5);
    checkEq("cal_pulse", pv, 5'b10000);
    checkEq("cal_errcode_clr", cmdBus.ErrCode, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checkEq("cal_no_early_done", cmdBus.CmdDone, 0);
    end
    foreach (calSeq[i]) begin
      AdcState = calSeq[i];
      tick();
    end
    checkEq("cal_done", cmdBus.CmdDone, 1);
    tick();

    // SLEEP with ADC stuck in DES_SAMPLING: 63 WAIT cycles then TIMEOUT
    pushExp(1'b1, 3'd3, 1'b0, 5'b00100);
    hostCmd(3'd3);
    checkEq("sleep_pulse", pv, 5'b00100);
    repeat (63) tick();
    checkEq("tmo_not_yet", cmdBus.CmdError, 0);
    checkEq("tmo_busy", Busy, 1);
    tick();
    checkEq("tmo_err", cmdBus.CmdError, 1);
    checkEq("tmo_errcode", cmdBus.ErrCode, 3);
    tick();

    // SLEEP aborted by autonomous shutdown 8 -> 13 -> 0
    pushExp(1'b1, 3'd4, 1'b0, 5'b00100);
    hostCmd(3'd3);
    tick();
    AdcState = 4'd13;
    tick();
    checkEq("abort_not_yet", cmdBus.CmdError, 0);
    AdcState = 4'd0;
    tick();
    checkEq("abort_err", cmdBus.CmdError, 1);
    checkEq("abort_errcode", cmdBus.ErrCode, 4);
    tick();

    pushExp(1'b0, 3'd0, 1'b0, 5'b00001);
    hostCmd(3'd1);
    tick();
    AdcState = 4'd8;
    tick();
    checkEq("repwr_done", cmdBus.CmdDone, 1);
    tick();

    // Reset during WAIT abandons the command
    hostCmd(3'd3);
    tick();
    Reset = 1'b1;
    tick();
    checkEq("midrst_busy", Busy, 0);
    checkEq("midrst_pulses", pv, 0);
    checkEq("midrst_done", cmdBus.CmdDone, 0);
    checkEq("midrst_error", cmdBus.CmdError, 0);
    Reset = 1'b0;
    tick();
    checkEq("midrst_ready", cmdBus.CmdReady, 1);

    // Auto-cal after 20 idle DES_SAMPLING cycles
    pushExp(1'b0, 3'd0, 1'b1, 5'b10000);
    AutoCalEnable = 1'b1;
    for (int i = 0; i < 19; i++) begin
      tick();
      checkEq("auto_wait", pv, 0);
    end
    tick();
    checkEq("auto_pulse", pv, 5'b10000);
    tick();
    AdcState = 4'd12;
    tick();
    AdcState = 4'd8;
    tick();
    checkEq("auto_done", cmdBus.CmdDone, 1);
    checkEq("auto_src", cmdBus.DoneSrc, 1);

    // Host request on the cycle auto-cal would start: host first, auto-cal follows
    repeat (20) tick();
    checkEq("collide_idle", pv, 0);
    pushExp(1'b1, 3'd1, 1'b0, 5'b00000);
    pushExp(1'b0, 3'd0, 1'b1, 5'b10000);
    hostCmd(3'd0);
    checkEq("collide_host_err", cmdBus.CmdError, 1);
    checkEq("collide_host_src", cmdBus.DoneSrc, 0);
    checkEq("collide_no_cal", pv, 0);
    tick();
    checkEq("collide_gap", pv, 0);
    tick();
    checkEq("collide_auto_pulse", pv, 5'b10000);
    tick();
    AdcState = 4'd12;
    tick();
    AdcState = 4'd8;
    tick();
    checkEq("collide_auto_done", cmdBus.CmdDone, 1);
    checkEq("collide_auto_src", cmdBus.DoneSrc, 1);
    tick();
    AutoCalEnable = 1'b0;
    tick();
    checkEq("sb_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
